// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: default sizes,
// port identifiers and the read-tracker entry layout.
package mem_arb_pkg;

    // Default memory geometry: 32 words of 32 bits.
    localparam int unsigned MEM_AW = 5;
    localparam int unsigned MEM_DW = 32;

    // Requester identifiers, also the encoding of the priority pointer.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // One stage of the read tracker: a read is in flight for port `id`.
    typedef struct packed {
        logic valid;
        logic id;
    } rd_ent_t;

    // Identifier of the port that is not `id`.
    function automatic logic other_port(input logic id);
        return (id == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker. The priority pointer only
// matters when both requesters are active; otherwise the lone requester wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    // Grant is one-hot or zero; prio breaks the tie under contention.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (prio == PORT1) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous memory between two
// requesters. One access is issued per cycle from registers; read data comes
// back two cycles after the grant and is steered by a small in-order tracker.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = MEM_AW,
    parameter int unsigned DW = MEM_DW
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,

    output logic [DW-1:0] rdata,

    output logic          W,
    output logic [AW-1:0] realaddr,
    output logic [DW-1:0] dout,
    input  logic [DW-1:0] din
);

    logic          prio;
    logic [1:0]    req_live;
    logic [1:0]    gnt;
    logic          any_gnt;
    logic          gnt_id;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    rd_ent_t       trk1;
    rd_ent_t       trk2;

    // Requests are ignored while reset is held so no grant can leak out.
    assign req_live = {req1, req0} & {2{resetn}};

    rr_pick2 u_pick (
        .req  (req_live),
        .prio (prio),
        .gnt  (gnt)
    );

    assign gnt0    = gnt[0];
    assign gnt1    = gnt[1];
    assign any_gnt = gnt[0] | gnt[1];
    assign gnt_id  = gnt[1] ? PORT1 : PORT0;

    // Mux the winning request onto the issue path.
    always_comb begin
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        if (gnt_id == PORT1) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    // Priority pointer: hand priority to the other port after each grant.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prio <= PORT0;
        end else if (any_gnt) begin
            prio <= other_port(gnt_id);
        end
    end

    // Issue register: drives the memory; address/data hold when idle so the
    // bus only toggles on real accesses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            W        <= 1'b0;
            realaddr <= '0;
            dout     <= '0;
        end else if (any_gnt) begin
            W        <= sel_we;
            realaddr <= sel_addr;
            dout     <= sel_wdata;
        end else begin
            W        <= 1'b0;
        end
    end

    // Read tracker: stage 1 lines up with the memory sampling the address,
    // stage 2 with din carrying the data. Writes enter as invalid bubbles.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            trk1 <= '0;
            trk2 <= '0;
        end else begin
            trk1.valid <= any_gnt & ~sel_we;
            trk1.id    <= gnt_id;
            trk2       <= trk1;
        end
    end

    // Response qualifiers; gated by reset so reads lost to a reset never
    // report, even in the cycle reset is first asserted.
    assign rvalid0 = resetn & trk2.valid & (trk2.id == PORT0);
    assign rvalid1 = resetn & trk2.valid & (trk2.id == PORT1);
    assign rdata   = din;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a synchronous memory model plus a transaction-level
// reference (grant rule, issued access, in-order read responses by due cycle).
module tb_mem_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, W;
    logic [DW-1:0] rdata, dout;
    logic [AW-1:0] realaddr;
    logic [DW-1:0] din = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .gnt0     (gnt0),
        .rvalid0  (rvalid0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .gnt1     (gnt1),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .W        (W),
        .realaddr (realaddr),
        .dout     (dout),
        .din      (din)
    );

    // Memory instance model: samples on the edge, read data one cycle later.
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (W) mem[realaddr] <= dout;
        din <= mem[realaddr];
    end

    // Reference state.
    typedef struct {
        int         due;
        bit         port;
        logic [31:0] data;
    } resp_t;

    logic [31:0] ref_mem [32];
    bit          ref_prio;
    logic        exp_w;
    logic [4:0]  exp_addr;
    logic [31:0] exp_dout;
    resp_t       pend[$];
    int          cyc = 0;
    bit          last_g0, last_g1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Compare all DUT outputs for the current cycle, then advance the model
    // across the upcoming clock edge.
    task automatic check_and_update();
        bit eg0, eg1, erv0, erv1;
        logic [31:0] erd;
        eg0 = 0; eg1 = 0;
        if (resetn) begin
            if (req0 && req1) begin
                eg0 = (ref_prio == 0);
                eg1 = (ref_prio == 1);
            end else begin
                eg0 = req0;
                eg1 = req1;
            end
        end
        chk("gnt0", 32'(gnt0), 32'(eg0));
        chk("gnt1", 32'(gnt1), 32'(eg1));
        chk("W", 32'(W), 32'(exp_w));
        chk("realaddr", 32'(realaddr), 32'(exp_addr));
        chk("dout", dout, exp_dout);

        erv0 = 0; erv1 = 0; erd = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            if (resetn) begin
                erv0 = (pend[0].port == 0);
                erv1 = (pend[0].port == 1);
                erd  = pend[0].data;
            end
            void'(pend.pop_front());
        end
        chk("rvalid0", 32'(rvalid0), 32'(erv0));
        chk("rvalid1", 32'(rvalid1), 32'(erv1));
        if (erv0 || erv1) chk("rdata", rdata, erd);

        last_g0 = eg0;
        last_g1 = eg1;
        if (!resetn) begin
            exp_w = 0; exp_addr = '0; exp_dout = '0; ref_prio = 0;
            pend.delete();
        end else if (eg0 || eg1) begin
            bit          p;
            logic        we;
            logic [4:0]  a;
            logic [31:0] d;
            p  = eg1;
            we = p ? we1 : we0;
            a  = p ? addr1 : addr0;
            d  = p ? wdata1 : wdata0;
            exp_w = we; exp_addr = a; exp_dout = d;
            ref_prio = ~p;
            // Accesses complete in grant order, so memory state at grant time
            // is what a read returns.
            if (we) ref_mem[a] = d;
            else pend.push_back('{due: cyc + 2, port: p, data: ref_mem[a]});
        end else begin
            exp_w = 0;
        end
        cyc++;
    endtask

    task automatic step(input bit rn,
                        input bit r0, input bit w0, input logic [4:0] a0, input logic [31:0] d0,
                        input bit r1, input bit w1, input logic [4:0] a1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        resetn = rn;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #1;
        check_and_update();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit          pr0, pw0, pr1, pw1, prn;
        logic [4:0]  pa0, pa1;
        logic [31:0] pd0, pd1;

        for (int i = 0; i < 32; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        ref_prio = 0; exp_w = 0; exp_addr = '0; exp_dout = '0;

        // Reset; first compared cycle shows reset values.
        @(posedge clk);
        #1;
        resetn = 0; req0 = 1; req1 = 1;
        @(posedge clk);
        #2;
        check_and_update();
        step(0, 1, 0, 1, 0, 1, 0, 2, 0);

        // Port 0 writes addr 3, then port 1 reads it back.
        step(1, 1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 0, 1, 0, 3, 0);
        idle(3);

        // Contention: both read every cycle; grants alternate.
        for (int i = 0; i < 6; i++) step(1, 1, 0, 3, 0, 1, 0, 5, 0);
        idle(2);

        // Write then immediate read of the same address.
        step(1, 1, 1, 7, 32'h1, 0, 0, 0, 0);
        step(1, 1, 0, 7, 0, 0, 0, 0, 0);
        idle(3);

        // Two reads from port 1, then reset drops them.
        step(1, 0, 0, 0, 0, 1, 0, 10, 0);
        step(1, 0, 0, 0, 0, 1, 0, 11, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 12, 0, 1, 0, 13, 0);
        idle(4);
        chk("prio_after_reset", 32'(last_g0), 32'(0));

        // Randomized traffic with the hold-until-granted rule and rare resets.
        pr0 = 0; pr1 = 0; pw0 = 0; pw1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pr0 || last_g0 || !prn) begin
                pr0 = ($urandom_range(0, 3) != 0);
                pw0 = $urandom_range(0, 1) == 1;
                pa0 = 5'($urandom_range(0, 7));
                pd0 = $urandom;
            end
            if (!pr1 || last_g1 || !prn) begin
                pr1 = ($urandom_range(0, 3) != 0);
                pw1 = $urandom_range(0, 1) == 1;
                pa1 = 5'($urandom_range(0, 7));
                pd1 = $urandom;
            end
            prn = ($urandom_range(0, 49) != 0);
            step(prn, pr0, pw0, pa0, pd0, pr1, pw1, pa1, pd1);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
